// File: rtl/conc_trace_capture.sv
// Trace capture for the b10 response side: timestamps cts/ctr/v_out samples into a buffer
// and drains them over valid/ready. Define CONC_TRACE_DELTA_EN for change-only capture.
module conc_trace_capture #(
    parameter int DEPTH = 31,
    parameter int AW    = 5,
    parameter int TSW   = 10
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_arm,
    input  logic             i_stop,
    input  logic             i_cts,
    input  logic             i_ctr,
    input  logic [3:0]       i_v_out,
    input  logic             i_rd_ready,
    output logic             o_rd_valid,
    output logic [TSW+5:0]   o_rd_data,
    output logic [AW:0]      o_count,
    output logic             o_full,
    output logic             o_busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_FULL    = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic [TSW-1:0]  r_ts;
    logic [TSW+5:0]  r_mem [0:DEPTH-1];

    logic [5:0]      w_sample;
    logic [TSW-1:0]  w_ts_next;
    logic            w_write;
    logic            w_fill;
    logic            w_rd_valid;
    logic            w_xfer;
    logic            w_last_rd;

    assign w_sample  = {i_cts, i_ctr, i_v_out};
    assign w_ts_next = (r_ts == {TSW{1'b1}}) ? r_ts : r_ts + TSW'(1);

`ifdef CONC_TRACE_DELTA_EN
    // Last value committed to the buffer; only meaningful once count is non-zero.
    logic [5:0] r_last;

    assign w_write = (r_state == S_CAPTURE) && ((r_count == '0) || (w_sample != r_last));

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_last <= '0;
        end else if (w_write) begin
            r_last <= w_sample;
        end
    end
`else
    assign w_write = (r_state == S_CAPTURE);
`endif

    assign w_fill     = w_write && (r_count == (AW+1)'(DEPTH - 1));
    assign w_rd_valid = (r_state == S_DRAIN) && ({1'b0, r_rd_ptr} < r_count);
    assign w_xfer     = w_rd_valid && i_rd_ready;
    assign w_last_rd  = w_xfer && ({1'b0, r_rd_ptr} == (r_count - (AW+1)'(1)));

    // Buffer storage carries no reset; rd_data is masked while nothing valid is presented.
    always_ff @(posedge i_clock) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= {r_ts, w_sample};
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ts     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_arm) begin
                        r_state  <= S_CAPTURE;
                        r_wr_ptr <= '0;
                        r_rd_ptr <= '0;
                        r_count  <= '0;
                        r_ts     <= '0;
                    end
                end
                S_CAPTURE: begin
                    r_ts <= w_ts_next;
                    if (w_write) begin
                        r_wr_ptr <= r_wr_ptr + AW'(1);
                        r_count  <= r_count + (AW+1)'(1);
                    end
                    // stop wins over the fill transition so the buffer goes straight to drain
                    if (i_stop) begin
                        r_state  <= S_DRAIN;
                        r_rd_ptr <= '0;
                    end else if (w_fill) begin
                        r_state <= S_FULL;
                    end
                end
                S_FULL: begin
                    r_ts <= w_ts_next;
                    if (i_stop) begin
                        r_state  <= S_DRAIN;
                        r_rd_ptr <= '0;
                    end
                end
                S_DRAIN: begin
                    if (r_count == '0) begin
                        r_state  <= S_IDLE;
                        r_rd_ptr <= '0;
                    end else if (w_xfer) begin
                        if (w_last_rd) begin
                            r_state  <= S_IDLE;
                            r_count  <= '0;
                            r_rd_ptr <= '0;
                        end else begin
                            r_rd_ptr <= r_rd_ptr + AW'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_rd_valid = w_rd_valid;
    assign o_rd_data  = w_rd_valid ? r_mem[r_rd_ptr] : '0;
    assign o_count    = r_count;
    assign o_full     = (r_count == (AW+1)'(DEPTH));
    assign o_busy     = (r_state != S_IDLE);

endmodule

// File: doc/conc_trace_capture.md
# conc_trace_capture

- Response-side counterpart of the concolic stimulus player.
- Samples the `b10` outputs (`cts`, `ctr`, `v_out`) every clock, timestamps each sample, and stores it in a trace buffer.
- After capture, the buffer is drained word by word over a valid/ready port to the bench's checker or `$fwrite` dumper.
- Sits in `conquest_tb` beside the `b10` instance, on the same `clock`/`reset`.

## Interface
- `DEPTH`, 31: number of trace entries (one per opcode RAM slot).
- `AW`, 5: pointer width, must satisfy 2^AW ≥ DEPTH.
- `TSW`, 10: timestamp width in cycles.
- `clock` in 1: single clock; all state updates on posedge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `arm` in 1: start a capture (honoured only in IDLE).
- `stop` in 1: end capture and begin drain (honoured in CAPTURE/FULL).
- `cts` in 1: DUT clear-to-send.
- `ctr` in 1: DUT clear-to-receive.
- `v_out` in 4: DUT vote output.
- `rd_ready` in 1: consumer accepts `rd_data`.
- `rd_valid` out 1: `rd_data` holds a valid trace word.
- `rd_data` out TSW+6: {timestamp[TSW-1:0], cts, ctr, v_out[3:0]}.
- `count` out AW+1: number of entries stored.
- `full` out 1: `count == DEPTH`.
- `busy` out 1: state is not IDLE.

## Operation
- States: IDLE, CAPTURE, FULL, DRAIN. Reset enters IDLE.
- IDLE:
  - `arm` = 1 → CAPTURE; `wr_ptr`, `count` and `ts` are cleared.
  - `stop` is ignored.
- CAPTURE:
  - Each cycle: write {ts, cts, ctr, v_out} at `wr_ptr`, then increment `wr_ptr`, `count` and `ts`.
  - `ts` saturates at 2^TSW−1; it does not wrap.
  - Write making `count == DEPTH` → FULL.
  - `stop` → DRAIN. The sample in the `stop` cycle is still written.
  - If `stop` coincides with the filling write, the write completes and the next state is DRAIN.
  - `arm` is ignored.
- FULL:
  - No writes; `ts` keeps counting (saturating).
  - `stop` → DRAIN.
- DRAIN:
  - `rd_ptr` starts at 0.
  - `rd_valid` = 1 whenever `rd_ptr < count`; `rd_data` = `mem[rd_ptr]`.
  - Transfer occurs when `rd_valid` && `rd_ready`; `rd_ptr` then increments.
  - Transfer of entry `count`−1 → IDLE, with `count` and `rd_ptr` cleared.
  - `arm` and `stop` are ignored.
- `rd_data` and `rd_valid` must hold stable while `rd_valid` && !`rd_ready`.
- Reset mid-operation: immediate return to IDLE; the buffer contents are don't-care.

## Timing
- Reset values: `rd_valid`=0, `rd_data`=0, `count`=0, `full`=0, `busy`=0.
- `arm` sampled at edge N:
  - `busy`=1 after edge N.
  - First sample is taken at edge N+1 with ts=0.
- `cts`, `ctr` and `v_out` are sampled at the posedge and need no synchroniser: the bench drives them off the DUT clock.
- `stop` sampled at edge M: `rd_valid`=1 after edge M, so first-word latency is 1 cycle.
- Drain throughput: one word per cycle when `rd_ready` is held at 1.
- `full` and `count` are registered and reflect the writes made up to the last edge.

## Configuration
- `CONC_TRACE_DELTA_EN` defined: change-only capture.
  - In CAPTURE, the first sample is always written.
  - Later samples are written only if {cts, ctr, v_out} differs from the last written value.
  - `ts` still advances every cycle, so timestamps show when each change happened.
- `CONC_TRACE_DELTA_EN` undefined: every CAPTURE cycle is written, and ts equals the entry index (until saturation).

## Test plan
- Reset during CAPTURE after 5 samples → next cycle: `busy`=0, `count`=0, `rd_valid`=0; a new `arm` restarts at ts=0.
- `arm`, hold v_out=4'h3 / cts=1 / ctr=0 for 4 cycles, then `stop` with `rd_ready`=1 → 5 words with ts 0..4, each data field 6'b10_0011.
- `arm`, never `stop` for 40 cycles → `full`=1 and `count`=31 after the 31st write; then `stop` drains 31 words, the last with ts=30.
- Drain with `rd_ready` toggling 1,0,0,1 → `rd_data` stable during stalls; words arrive in order with no duplicates or drops.
- With `CONC_TRACE_DELTA_EN`, `v_out` pattern 1,1,1,2,2,1 → 3 entries at ts 0, 3, 5.
- `stop` on the same edge as the 31st write → `count`=31 and direct entry to DRAIN, not FULL.
